// File: rtl/test_pkg_a.sv
// Shared link-level definitions: the cycle type carried by each data beat.
package test_pkg_a;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        DONE  = 2'd2,
        RSVD  = 2'd3
    } CYCLE_TYPE_E;

endpackage

// File: rtl/test_pkg_b.sv
// Shared pipelined-write link definitions: command/data beat layouts, the reassembled
// transaction and the receiver state encoding.
package test_pkg_b;

    localparam int MAX_WR_CYCLES = 4;

    typedef enum logic [2:0] {
        STD          = 3'd0,
        MULTI_WDONE  = 3'd1,
        SINGLE_WDONE = 3'd2
    } WRITE_TYPE_E;

    typedef struct packed {
        logic       val;
        logic [2:0] write_type;
        logic [1:0] num_cycles;
        logic [3:0] rsvd;
    } write_cmd_t;

    typedef struct packed {
        logic [1:0] cycle_type;
        logic [7:0] dat;
    } write_data_t;

    // dat[0] is the first data beat of the transaction
    typedef struct packed {
        write_cmd_t                         cmd;
        write_data_t [MAX_WR_CYCLES-1:0]    dat;
    } pipelined_write_t;

    typedef enum logic {
        S_CMD  = 1'b0,
        S_DATA = 1'b1
    } rx_state_e;

    localparam int XACT_W = $bits(pipelined_write_t);
    localparam int FIFO_W = XACT_W + 3;

    // num_cycles==0 encodes the maximum burst length
    function automatic logic [2:0] beat_count(input logic [1:0] num_cycles);
        return (num_cycles == 2'd0) ? 3'(MAX_WR_CYCLES) : {1'b0, num_cycles};
    endfunction

endpackage

// File: rtl/pipelined_write_rx_fifo.sv
// Small first-word-fall-through FIFO holding completed transactions; head data reads
// as zero while empty.
module pipelined_write_rx_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 53
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count_reg == CW'(DEPTH));
    assign valid   = (count_reg != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipelined_write_rx.sv
// Pipelined-write link deframer: reassembles cmd + data beats into transactions and queues them.
// Define PIPELINED_WRITE_RX_TIMEOUT_EN to abort transactions stalled by too many IDLE beats.
module pipelined_write_rx
    import test_pkg_a::*;
    import test_pkg_b::*;
#(
    parameter int OUT_DEPTH      = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  link_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [49:0] out_xact_o,
    output logic [2:0]  out_ncyc_o,
    output logic        wdone_o,
    output logic        err_proto_o,
    output logic        err_ovf_o,
    input  logic        err_clr_i,
    output logic        busy_o
);

    rx_state_e        state_reg;
    write_cmd_t       cmd_reg;
    write_data_t      slot_reg [MAX_WR_CYCLES];
    logic [1:0]       idx_reg;
    logic             wdone_reg;
    logic             err_proto_reg;
    logic             err_ovf_reg;

    write_cmd_t       cmd_in;
    write_data_t      dat_in;
    logic [1:0]       last_idx;
    logic             cmd_accept;
    logic             cmd_reject;
    logic             idle_beat;
    logic             take_valid;
    logic             take_done;
    logic             bad_beat;
    logic             timeout_hit;
    logic             fifo_full;
    logic             fifo_pop;
    logic             push_ok;
    logic             push;
    logic             proto_set;
    logic             ovf_set;
    logic             wdone_next;
    pipelined_write_t push_xact;
    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_dout;

    assign cmd_in   = link_i;
    assign dat_in   = link_i;
    // num_cycles-1 wraps 0 to 3, matching the 4-beat encoding of num_cycles==0
    assign last_idx = cmd_reg.num_cycles - 2'd1;

    assign cmd_accept = (state_reg == S_CMD) && cmd_in.val && (cmd_in.write_type <= 3'd2);
    assign cmd_reject = (state_reg == S_CMD) && cmd_in.val && (cmd_in.write_type > 3'd2);

    always_comb begin
        idle_beat  = 1'b0;
        take_valid = 1'b0;
        take_done  = 1'b0;
        bad_beat   = 1'b0;
        if (state_reg == S_DATA) begin
            if (dat_in.cycle_type == IDLE) begin
                idle_beat = 1'b1;
            end else if (dat_in.cycle_type == VALID && idx_reg != last_idx) begin
                take_valid = 1'b1;
            end else if (dat_in.cycle_type == DONE && idx_reg == last_idx) begin
                take_done = 1'b1;
            end else begin
                bad_beat = 1'b1;
            end
        end
    end

`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt_reg;

    assign timeout_hit = idle_beat && (idle_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg <= '0;
        end else if (idle_beat && !timeout_hit) begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end else begin
            idle_cnt_reg <= '0;
        end
    end
`else
    // constant false; the expression only keeps TIMEOUT_CYCLES referenced
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    assign fifo_pop  = out_valid_o && out_ready_i;
    assign push_ok   = !fifo_full || fifo_pop;
    assign push      = take_done && push_ok;
    assign ovf_set   = take_done && !push_ok;
    assign proto_set = cmd_reject || bad_beat || timeout_hit;

    assign wdone_next = ((cmd_reg.write_type == MULTI_WDONE) && (take_valid || take_done))
                     || ((cmd_reg.write_type == SINGLE_WDONE) && push);

    // The final beat goes straight into the pushed word rather than via its slot
    always_comb begin
        push_xact.cmd = cmd_reg;
        for (int i = 0; i < MAX_WR_CYCLES; i++) begin
            push_xact.dat[i] = slot_reg[i];
        end
        push_xact.dat[idx_reg] = dat_in;
    end

    assign fifo_din = {push_xact, beat_count(cmd_reg.num_cycles)};

    genvar gi;
    generate
        for (gi = 0; gi < MAX_WR_CYCLES; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg[gi] <= '0;
                end else if (cmd_accept) begin
                    slot_reg[gi] <= '0;
                end else if (take_valid && idx_reg == 2'(gi)) begin
                    slot_reg[gi] <= dat_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_CMD;
            cmd_reg       <= '0;
            idx_reg       <= '0;
            wdone_reg     <= 1'b0;
            err_proto_reg <= 1'b0;
            err_ovf_reg   <= 1'b0;
        end else begin
            wdone_reg     <= wdone_next;
            err_proto_reg <= proto_set || (err_proto_reg && !err_clr_i);
            err_ovf_reg   <= ovf_set || (err_ovf_reg && !err_clr_i);
            if (state_reg == S_CMD) begin
                if (cmd_accept) begin
                    cmd_reg   <= cmd_in;
                    idx_reg   <= '0;
                    state_reg <= S_DATA;
                end
            end else begin
                if (take_valid) begin
                    idx_reg <= idx_reg + 2'd1;
                end else if (take_done || bad_beat || timeout_hit) begin
                    state_reg <= S_CMD;
                end
            end
        end
    end

    pipelined_write_rx_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (fifo_din),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .valid (out_valid_o),
        .dout  (fifo_dout)
    );

    assign out_xact_o  = fifo_dout[FIFO_W-1:3];
    assign out_ncyc_o  = fifo_dout[2:0];
    assign wdone_o     = wdone_reg;
    assign err_proto_o = err_proto_reg;
    assign err_ovf_o   = err_ovf_reg;
    assign busy_o      = (state_reg == S_DATA);

endmodule

// File: tb/tb_pipelined_write_rx.sv
// Directed bench for pipelined_write_rx: transaction-level model (queue FIFO) checked every cycle,
// plus literal expectations per scenario. Honours PIPELINED_WRITE_RX_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_pipelined_write_rx;

    localparam int DEPTH = 2;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  link = '0;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        out_valid;
    logic [49:0] out_xact;
    logic [2:0]  out_ncyc;
    logic        wdone;
    logic        err_proto;
    logic        err_ovf;
    logic        busy;

    pipelined_write_rx #(.OUT_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .link_i      (link),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_xact_o  (out_xact),
        .out_ncyc_o  (out_ncyc),
        .wdone_o     (wdone),
        .err_proto_o (err_proto),
        .err_ovf_o   (err_ovf),
        .err_clr_i   (err_clr),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [49:0] xact;
        logic [2:0]  ncyc;
    } exp_t;

    exp_t        q[$];
    bit          m_in;
    logic [9:0]  m_cmd;
    logic [9:0]  m_slot [4];
    int          m_got, m_n, m_idle;
    bit          e_wdone, e_proto, e_ovf;
    int          checks = 0;
    int          failures = 0;
    int          wd_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [9:0] mk_cmd(input int wt, input int nc);
        return {1'b1, 3'(wt), 2'(nc), 4'h0};
    endfunction

    function automatic logic [9:0] mk_dat(input int ct, input int d);
        return {2'(ct), 8'(d)};
    endfunction

    task automatic model_reset();
        q.delete();
        m_in = 0; m_got = 0; m_n = 0; m_idle = 0;
        e_wdone = 0; e_proto = 0; e_ovf = 0;
    endtask

    // One link beat of the protocol, applied to the transaction-level model
    task automatic model_step(input logic [9:0] beat, input logic rdy, input logic clr);
        bit wd = 0, ps = 0, os = 0;
        int wt, ct;
        exp_t e;
        if (q.size() > 0 && rdy) q.delete(0);
        if (!m_in) begin
            if (beat[9]) begin
                wt = int'(beat[8:6]);
                if (wt <= 2) begin
                    m_in = 1; m_cmd = beat; m_got = 0; m_idle = 0;
                    m_n = (beat[5:4] == 2'd0) ? 4 : int'(beat[5:4]);
                    for (int i = 0; i < 4; i++) m_slot[i] = '0;
                end else begin
                    ps = 1;
                end
            end
        end else begin
            ct = int'(beat[9:8]);
            wt = int'(m_cmd[8:6]);
            if (ct == 0) begin
                m_idle++;
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
                if (m_idle >= TO) begin
                    ps = 1; m_in = 0;
                end
`endif
            end else if (ct == 1 && m_got < m_n - 1) begin
                m_slot[m_got] = beat; m_got++; m_idle = 0;
                wd = (wt == 1);
            end else if (ct == 2 && m_got == m_n - 1) begin
                m_slot[m_got] = beat; m_in = 0;
                if (q.size() < DEPTH) begin
                    e.xact = {m_cmd, m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
                    e.ncyc = 3'(m_n);
                    q.push_back(e);
                    wd = (wt == 1 || wt == 2);
                end else begin
                    os = 1;
                    wd = (wt == 1);
                end
            end else begin
                ps = 1; m_in = 0;
            end
        end
        e_wdone = wd;
        e_proto = ps || (e_proto && !clr);
        e_ovf   = os || (e_ovf && !clr);
    endtask

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_xact", 64'(out_xact), 64'(q[0].xact));
            check("out_ncyc", 64'(out_ncyc), 64'(q[0].ncyc));
        end else begin
            check("out_xact_empty", 64'(out_xact), 64'd0);
        end
        check("wdone", 64'(wdone), 64'(e_wdone));
        check("err_proto", 64'(err_proto), 64'(e_proto));
        check("err_ovf", 64'(err_ovf), 64'(e_ovf));
        check("busy", 64'(busy), 64'(m_in));
    endtask

    task automatic step(input logic [9:0] beat, input logic rdy, input logic clr);
        link = beat; out_ready = rdy; err_clr = clr;
        model_step(beat, rdy, clr);
        @(posedge clk); #1;
        check_outputs();
        if (wdone === 1'b1) wd_count++;
        $display("beat=%h rdy=%0b clr=%0b -> valid=%0b ncyc=%0d wdone=%0b ep=%0b eo=%0b busy=%0b",
                 beat, rdy, clr, out_valid, out_ncyc, wdone, err_proto, err_ovf, busy);
    endtask

    initial begin
        logic [49:0] x1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_xact", 64'(out_xact), 64'd0);
        check("rst_ncyc", 64'(out_ncyc), 64'd0);
        check("rst_wdone", 64'(wdone), 64'd0);
        check("rst_errs", 64'({err_proto, err_ovf}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // 1: SINGLE, two beats
        wd_count = 0;
        step(mk_cmd(2, 2), 1, 0);
        step(mk_dat(1, 8'hA1), 1, 0);
        step(mk_dat(2, 8'hB2), 1, 0);
        x1 = {mk_cmd(2, 2), 10'h000, 10'h000, 10'h2B2, 10'h1A1};
        check("t1_xact", 64'(out_xact), 64'(x1));
        check("t1_ncyc", 64'(out_ncyc), 64'd2);
        check("t1_wdone", 64'(wdone), 64'd1);
        step(10'h000, 1, 0);
        check("t1_wd_count", 64'(wd_count), 64'd1);

        // 2: MULTI, num_cycles=0 -> 4 beats with an IDLE bubble
        wd_count = 0;
        step(mk_cmd(1, 0), 1, 0);
        step(mk_dat(1, 8'h10), 1, 0);
        step(mk_dat(0, 8'h00), 1, 0);
        step(mk_dat(1, 8'h11), 1, 0);
        step(mk_dat(1, 8'h12), 1, 0);
        step(mk_dat(2, 8'h13), 1, 0);
        check("t2_ncyc", 64'(out_ncyc), 64'd4);
        step(10'h000, 1, 0);
        check("t2_wd_count", 64'(wd_count), 64'd4);

        // 3: DONE too early, then a good transaction
        step(mk_cmd(0, 3), 1, 0);
        step(mk_dat(1, 8'h21), 1, 0);
        step(mk_dat(2, 8'h22), 1, 0);
        check("t3_proto", 64'(err_proto), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_nopush", 64'(out_valid), 64'd0);
        step(mk_cmd(0, 1), 1, 0);
        step(mk_dat(2, 8'h23), 1, 0);
        check("t3_good", 64'(out_valid), 64'd1);
        step(10'h000, 1, 1);

        // 4: sink stalled, three back-to-back one-beat transactions
        wd_count = 0;
        step(mk_cmd(2, 1), 0, 0);
        step(mk_dat(2, 8'h31), 0, 0);
        step(mk_cmd(2, 1), 0, 0);
        step(mk_dat(2, 8'h32), 0, 0);
        step(mk_cmd(2, 1), 0, 0);
        step(mk_dat(2, 8'h33), 0, 0);
        check("t4_ovf", 64'(err_ovf), 64'd1);
        check("t4_wd_count", 64'(wd_count), 64'd2);
        check("t4_head", 64'(out_xact[9:0]), 64'h231);
        step(10'h000, 1, 0);
        check("t4_second", 64'(out_xact[9:0]), 64'h232);
        step(10'h000, 1, 0);
        check("t4_drained", 64'(out_valid), 64'd0);

        // 5: bad write_type, then clear
        step(10'h000, 0, 1);
        step(mk_cmd(5, 1), 0, 0);
        check("t5_proto", 64'(err_proto), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        step(10'h000, 0, 1);
        check("t5_clr", 64'(err_proto), 64'd0);

        // reserved cycle type aborts the transaction
        step(mk_cmd(0, 2), 1, 0);
        step(mk_dat(3, 8'h44), 1, 0);
        check("rsvd_proto", 64'(err_proto), 64'd1);
        step(10'h000, 1, 1);

        // 6: long IDLE stall inside a transaction
        step(mk_cmd(2, 2), 1, 0);
        step(mk_dat(1, 8'h51), 1, 0);
        for (int i = 0; i < TO; i++) step(10'h000, 1, 0);
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
        check("t6_timeout_proto", 64'(err_proto), 64'd1);
        check("t6_timeout_busy", 64'(busy), 64'd0);
        step(10'h000, 1, 1);
`else
        check("t6_still_busy", 64'(busy), 64'd1);
        step(10'h000, 1, 0);
        step(mk_dat(2, 8'h52), 1, 0);
        check("t6_done", 64'(out_valid), 64'd1);
        check("t6_ncyc", 64'(out_ncyc), 64'd2);
        step(10'h000, 1, 0);
`endif

        // reset in the middle of a transaction discards it
        step(mk_cmd(1, 3), 1, 0);
        step(mk_dat(1, 8'h61), 1, 0);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        step(mk_cmd(0, 1), 0, 0);
        step(mk_dat(2, 8'h62), 0, 0);
        check("post_rst_good", 64'(out_xact[9:0]), 64'h262);
        step(10'h000, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
